// File: rtl/rom4_pkg.sv
// -----------------------------------------------------------------------------
// rom4_pkg
// Shared widths and the reader state encoding for the 16x8 rom4 lookup ROM
// and its sequential reader.
// -----------------------------------------------------------------------------
package rom4_pkg;

  localparam int ROM4_ADDR_W  = 4;
  localparam int ROM4_DATA_W  = 8;
  localparam int ROM4_DWELL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DWELL   = 3'd3,
    ST_DONE    = 3'd4
  } rom4_rd_state_t;

endpackage

// File: rtl/rom4_dwell_timer.sv
// -----------------------------------------------------------------------------
// rom4_dwell_timer
// 8-bit down-counter used to time the idle gap after each accepted word.
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous, active-high reset (count clears to 0)
//   load       in   load load_value into the counter
//   load_value in   8-bit reload value
//   dec        in   decrement by one (saturates at zero)
//   expire     out  high while the count is 1, i.e. the last dwell cycle
// -----------------------------------------------------------------------------
module rom4_dwell_timer
  import rom4_pkg::*;
(
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [ROM4_DWELL_W-1:0] load_value,
  input  logic                    dec,
  output logic                    expire
);

  logic [ROM4_DWELL_W-1:0] count;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Expiring at 1 rather than 0 makes a load of N yield exactly N dwell cycles.
  assign expire = (count == ROM4_DWELL_W'(1));

endmodule

// File: rtl/rom4_reader.sv
// -----------------------------------------------------------------------------
// rom4_reader
// Walks the rom4 address range START_ADDR..END_ADDR (inclusive, modulo 16),
// captures each word and offers it downstream on a valid/ready handshake,
// with DWELL idle cycles after every accepted word except the last.
//
// Parameters:
//   START_ADDR  first address read
//   END_ADDR    last address read (inclusive)
//   DWELL       idle cycles after each accepted word, 0..255
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   begin a scan (sampled only in IDLE)
//   addr       out  registered address to rom4
//   rom_data   in   rom4 data, combinational in addr
//   out_data   out  captured ROM word
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts the word
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the final word is accepted
//   checksum   out  modulo-256 sum of transferred words
//                   (only when ROM4_READER_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
module rom4_reader
  import rom4_pkg::*;
#(
  parameter logic [ROM4_ADDR_W-1:0] START_ADDR = 4'h0,
  parameter logic [ROM4_ADDR_W-1:0] END_ADDR   = 4'hF,
  parameter int unsigned            DWELL      = 0
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   start,
  output logic [ROM4_ADDR_W-1:0] addr,
  input  logic [ROM4_DATA_W-1:0] rom_data,
  output logic [ROM4_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
`ifdef ROM4_READER_CHECKSUM_EN
  ,
  output logic [ROM4_DATA_W-1:0] checksum
`endif
);

  localparam logic [ROM4_DWELL_W-1:0] DWELL_LOAD = ROM4_DWELL_W'(DWELL);

  rom4_rd_state_t state, state_next;
  logic           xfer;
  logic           accept_start;
  logic           addr_step;
  logic           timer_load;
  logic           timer_expire;

  assign xfer         = out_valid && out_ready;
  assign accept_start = (state == ST_IDLE) && start;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    addr_step  = 1'b0;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (xfer) begin
          if (addr == END_ADDR) begin
            state_next = ST_DONE;
          end else if (DWELL_LOAD != '0) begin
            state_next = ST_DWELL;
            timer_load = 1'b1;
          end else begin
            state_next = ST_FETCH;
            addr_step  = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        if (timer_expire) begin
          state_next = ST_FETCH;
          addr_step  = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= START_ADDR;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      // busy/done decode the next state so they line up with the state register.
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);

      // Address wraps naturally through 4'hF -> 4'h0.
      if (accept_start) begin
        addr <= START_ADDR;
      end else if (addr_step) begin
        addr <= addr + 1'b1;
      end

      if (state == ST_FETCH) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ROM4_READER_CHECKSUM_EN
  always_ff @(posedge sysclk) begin
    if (reset || accept_start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + out_data;
    end
  end
`endif

  rom4_dwell_timer u_dwell_timer (
    .sysclk     (sysclk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (DWELL_LOAD),
    .dec        (state == ST_DWELL),
    .expire     (timer_expire)
  );

endmodule

// File: tb/tb_rom4_reader.sv
// -----------------------------------------------------------------------------
// tb_rom4_reader
// Three reader instances against a ROM model rom_data = {addr, ~addr}:
//   a: default range 0..F, DWELL=0   (main scans, stall, reset, start tests)
//   b: range E..1 (wraps), DWELL=3
//   c: range 5..5 (single word)
// Stimulus pushes expected words into per-instance queues; a negedge monitor
// pops and compares on every transfer. Checksum checks are compiled in when
// ROM4_READER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_rom4_reader;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [3:0] addr_a, addr_b, addr_c;
  logic [7:0] rom_a, rom_b, rom_c;
  logic [7:0] out_data_a, out_data_b, out_data_c;
  logic       out_valid_a, out_valid_b, out_valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [2:0] done_v;
`ifdef ROM4_READER_CHECKSUM_EN
  logic [7:0] checksum_a, checksum_b, checksum_c;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_xfer_b = -1;
  logic [7:0] q_a[$], q_b[$], q_c[$];
  logic [7:0] sum_a = 8'h00, sum_b = 8'h00, sum_c = 8'h00;
  logic [2:0] prev_done = 3'b000;

  always #5 sysclk = ~sysclk;

  assign rom_a  = {addr_a, ~addr_a};
  assign rom_b  = {addr_b, ~addr_b};
  assign rom_c  = {addr_c, ~addr_c};
  assign done_v = {done_c, done_b, done_a};

  rom4_reader #(.START_ADDR(4'h0), .END_ADDR(4'hF), .DWELL(0)) u_a (
    .sysclk(sysclk), .reset(reset), .start(start_a), .addr(addr_a),
    .rom_data(rom_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(ready_a), .busy(busy_a), .done(done_a)
`ifdef ROM4_READER_CHECKSUM_EN
    , .checksum(checksum_a)
`endif
  );

  rom4_reader #(.START_ADDR(4'hE), .END_ADDR(4'h1), .DWELL(3)) u_b (
    .sysclk(sysclk), .reset(reset), .start(start_b), .addr(addr_b),
    .rom_data(rom_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(ready_b), .busy(busy_b), .done(done_b)
`ifdef ROM4_READER_CHECKSUM_EN
    , .checksum(checksum_b)
`endif
  );

  rom4_reader #(.START_ADDR(4'h5), .END_ADDR(4'h5), .DWELL(0)) u_c (
    .sysclk(sysclk), .reset(reset), .start(start_c), .addr(addr_c),
    .rom_data(rom_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(ready_c), .busy(busy_c), .done(done_c)
`ifdef ROM4_READER_CHECKSUM_EN
    , .checksum(checksum_c)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic extra_word(input string name, input logic [7:0] data);
    vectors++;
    miscompares++;
    $display("FAIL %s: got word %02h, expected no transfer", name, data);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] rom_word(input logic [3:0] a);
    return {a, ~a};
  endfunction

  task automatic push_scan_a(input logic [3:0] first, input logic [3:0] last);
    logic [3:0] a;
    a = first;
    q_a.push_back(rom_word(a));
    while (a != last) begin
      a = a + 4'h1;
      q_a.push_back(rom_word(a));
    end
  endtask

  task automatic wait_done(input int idx, input int limit);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!done_v[idx] && k < limit);
    check($sformatf("done_seen_%0d", idx), 32'(done_v[idx]), 32'd1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // Scoreboard monitor: a transfer occurs at the next posedge when valid&&ready.
  always @(negedge sysclk) begin
    if (reset) begin
      sum_a     = 8'h00;
      sum_b     = 8'h00;
      sum_c     = 8'h00;
      prev_done = 3'b000;
    end else begin
      if (out_valid_a && ready_a) begin
        if (q_a.size() == 0) extra_word("a_extra", out_data_a);
        else begin
          check("a_word", 32'(out_data_a), 32'(q_a.pop_front()));
          sum_a = sum_a + out_data_a;
        end
      end
      if (out_valid_b && ready_b) begin
        if (q_b.size() == 0) extra_word("b_extra", out_data_b);
        else begin
          check("b_word", 32'(out_data_b), 32'(q_b.pop_front()));
          sum_b = sum_b + out_data_b;
        end
        // DWELL=3 plus FETCH and PRESENT: 5 cycles between transfers.
        if (last_xfer_b >= 0) check("b_xfer_gap", cyc - last_xfer_b, 32'd5);
        last_xfer_b = cyc;
      end
      if (out_valid_c && ready_c) begin
        if (q_c.size() == 0) extra_word("c_extra", out_data_c);
        else begin
          check("c_word", 32'(out_data_c), 32'(q_c.pop_front()));
          sum_c = sum_c + out_data_c;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) check($sformatf("done_single_%0d", i), 32'(prev_done[i]), 32'd0);
      end
`ifdef ROM4_READER_CHECKSUM_EN
      if (done_a) begin check("a_checksum", 32'(checksum_a), 32'(sum_a)); sum_a = 8'h00; end
      if (done_b) begin check("b_checksum", 32'(checksum_b), 32'(sum_b)); sum_b = 8'h00; end
      if (done_c) begin check("c_checksum", 32'(checksum_c), 32'(sum_c)); sum_c = 8'h00; end
`endif
      prev_done = done_v;
    end
  end

  initial begin
    int t0;
    bit found;

    // Reset values.
    repeat (2) step();
    check("rst_addr_a", 32'(addr_a), 32'h0);
    check("rst_addr_b", 32'(addr_b), 32'hE);
    check("rst_addr_c", 32'(addr_c), 32'h5);
    check("rst_out_data_a", 32'(out_data_a), 32'h00);
    check("rst_valid_busy_done", 32'({out_valid_a, busy_a, done_a, out_valid_b, busy_b, done_b}), 32'h0);
`ifdef ROM4_READER_CHECKSUM_EN
    check("rst_checksum_a", 32'(checksum_a), 32'h00);
`endif
    reset = 1'b0;
    step();

    // 1: full scan, ready tied high, latency and done timing.
    push_scan_a(4'h0, 4'hF);
    t0 = cyc;
    pulse_start_a();
    check("s1_busy_after_start", 32'(busy_a), 32'd1);
    check("s1_valid_in_fetch", 32'(out_valid_a), 32'd0);
    step();
    check("s1_first_valid", 32'(out_valid_a), 32'd1);
    check("s1_first_word", 32'(out_data_a), 32'h0F);
    wait_done(0, 60);
    check("s1_done_cycle", cyc - t0, 32'd33);
    check("s1_done_addr", 32'(addr_a), 32'hF);
    step();
    check("s1_done_low", 32'({done_a, busy_a}), 32'd0);

    // 2: stall at word 3 for 5 cycles.
    push_scan_a(4'h0, 4'hF);
    pulse_start_a();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid_a && addr_a == 4'h3) found = 1'b1;
      else step();
    end
    check("s2_word3_reached", 32'(found), 32'd1);
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_hold_valid", 32'(out_valid_a), 32'd1);
      check("s2_hold_data", 32'(out_data_a), 32'h3C);
    end
    ready_a = 1'b1;
    wait_done(0, 60);
    step();

    // 4: reset during PRESENT of word 7, then restart from word 0.
    push_scan_a(4'h0, 4'h6);
    pulse_start_a();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_valid_a && addr_a == 4'h7) found = 1'b1;
      else step();
    end
    check("s4_word7_reached", 32'(found), 32'd1);
    reset   = 1'b1;
    ready_a = 1'b0;
    step();
    check("s4_rst_valid", 32'(out_valid_a), 32'd0);
    check("s4_rst_busy", 32'(busy_a), 32'd0);
    check("s4_rst_addr", 32'(addr_a), 32'h0);
    check("s4_rst_data", 32'(out_data_a), 32'h00);
    reset   = 1'b0;
    ready_a = 1'b1;
    step();
    push_scan_a(4'h0, 4'hF);
    t0 = cyc;
    pulse_start_a();
    check("s4_restart_addr", 32'(addr_a), 32'h0);
    wait_done(0, 60);
    check("s4_done_cycle", cyc - t0, 32'd33);
    step();

    // 5a: start pulse mid-scan is ignored.
    push_scan_a(4'h0, 4'hF);
    t0 = cyc;
    pulse_start_a();
    repeat (9) step();
    pulse_start_a();
    wait_done(0, 60);
    check("s5_midstart_done_cycle", cyc - t0, 32'd33);
    step();

    // 5b: start held high gives back-to-back scans with one IDLE cycle between.
    push_scan_a(4'h0, 4'hF);
    push_scan_a(4'h0, 4'hF);
    t0 = cyc;
    start_a = 1'b1;
    wait_done(0, 60);
    check("s5_held_done1", cyc - t0, 32'd33);
    step();
    check("s5_idle_gap", 32'({busy_a, done_a}), 32'd0);
    step();
    check("s5_retrigger_busy", 32'(busy_a), 32'd1);
    check("s5_retrigger_addr", 32'(addr_a), 32'h0);
    start_a = 1'b0;
    t0 = cyc;
    wait_done(0, 60);
    check("s5_held_done2", cyc - t0, 32'd32);
    step();

    // 3: wrapping range E..1 with DWELL=3.
    q_b.push_back(8'hE1);
    q_b.push_back(8'hF0);
    q_b.push_back(8'h0F);
    q_b.push_back(8'h1E);
    t0 = cyc;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    wait_done(1, 40);
    check("s3_done_cycle", cyc - t0, 32'd18);
    check("s3_done_addr", 32'(addr_b), 32'h1);
    step();

    // 6: single-word range 5..5.
    q_c.push_back(8'h5A);
    t0 = cyc;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    wait_done(2, 10);
    check("s6_done_cycle", cyc - t0, 32'd3);
    step();
    check("s6_done_low", 32'({done_c, busy_c}), 32'd0);

    step();
    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    check("c_queue_empty", 32'(q_c.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
